// File: rtl/fft_output_unloader.sv
// FFT output reorder/unloader. Butterfly pairs are written to a ping-pong RAM at bit-reversed
// bin addresses, and each completed frame is read back as natural-order bin pairs (2j, 2j+1).
module fft_output_unloader #(
    parameter int DATA_W = 32,
    parameter int LOG2N  = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid_in,
    input  logic [DATA_W-1:0] i_data_a_real,
    input  logic [DATA_W-1:0] i_data_a_imag,
    input  logic [DATA_W-1:0] i_data_b_real,
    input  logic [DATA_W-1:0] i_data_b_imag,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_0_real,
    output logic [DATA_W-1:0] o_data_0_imag,
    output logic [DATA_W-1:0] o_data_1_real,
    output logic [DATA_W-1:0] o_data_1_imag,
    output logic [LOG2N-2:0]  o_pair_idx,
    output logic              o_last,
    output logic              o_frame_drop,
    output logic              o_overflow
);
    localparam int PW  = LOG2N - 1;
    localparam int WW  = 2 * DATA_W;
    localparam int PLW = 2 * WW + PW;

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_wr_cnt, r_rd_j, w_rd_j_nxt, w_wr_rev;
    logic           r_wbank, r_rbank;
    logic           r_frame_drop, r_overflow;

    logic [WW-1:0]  r_mem [0:(1<<(LOG2N+1))-1];
    logic           r_rd_valid;
    logic [WW-1:0]  r_rd_d0, r_rd_d1;
    logic [PW-1:0]  r_rd_idx;

    logic [PLW-1:0] r_fifo_mem [0:1];
    logic           r_fifo_wp, r_fifo_rp;
    logic [1:0]     r_fifo_cnt;
    logic           r_out_valid;
    logic [PLW-1:0] r_out_payload;

    logic w_frame_done, w_room, w_issue, w_release, w_handover, w_drop;
    logic w_out_take, w_fifo_empty, w_pop, w_push;
    logic [PLW-1:0] w_rd_payload;

    function automatic logic [PW-1:0] rev_bits(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        for (int i = 0; i < PW; i++) r[i] = v[PW-1-i];
        return r;
    endfunction

    assign w_wr_rev     = rev_bits(r_wr_cnt);
    assign w_frame_done = i_valid_in && (&r_wr_cnt);
    // A new read may only be issued if the skid FIFO can absorb it plus the one already in the RAM stage.
    assign w_room       = (r_fifo_cnt == 2'd0) || ((r_fifo_cnt == 2'd1) && !r_rd_valid);
    assign w_issue      = (r_state == S_READ) && w_room;
    assign w_release    = w_issue && (&r_rd_j);
    assign w_handover   = w_frame_done && ((r_state == S_IDLE) || w_release);
    assign w_drop       = w_frame_done && !w_handover;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_j_nxt  = r_rd_j;
        if (w_issue) w_rd_j_nxt = r_rd_j + 1'b1;
        if (w_release) w_state_nxt = S_IDLE;
        if (w_handover) begin
            w_state_nxt = S_READ;
            w_rd_j_nxt  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_rd_j       <= '0;
            r_wr_cnt     <= '0;
            r_wbank      <= 1'b0;
            r_rbank      <= 1'b0;
            r_frame_drop <= 1'b0;
            r_overflow   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_idx     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_j       <= w_rd_j_nxt;
            if (i_valid_in) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_handover) begin
                r_rbank <= r_wbank;
                r_wbank <= ~r_wbank;
            end
            r_frame_drop <= w_drop;
            r_overflow   <= r_overflow | w_drop;
            r_rd_valid   <= w_issue;
            if (w_issue) r_rd_idx <= r_rd_j;
        end
    end

    // Writer and reader always address opposite banks, so port sharing never collides.
    always_ff @(posedge i_clk) begin
        if (i_valid_in) begin
            r_mem[{r_wbank, 1'b0, w_wr_rev}] <= {i_data_a_real, i_data_a_imag};
            r_mem[{r_wbank, 1'b1, w_wr_rev}] <= {i_data_b_real, i_data_b_imag};
        end
        if (w_issue) begin
            r_rd_d0 <= r_mem[{r_rbank, r_rd_j, 1'b0}];
            r_rd_d1 <= r_mem[{r_rbank, r_rd_j, 1'b1}];
        end
    end

    // Output stream: a pair moves on every edge where o_valid && i_ready; while o_valid is high
    // and i_ready low, every o_* payload field holds its value.
    assign w_rd_payload = {r_rd_d0, r_rd_d1, r_rd_idx};
    assign w_out_take   = !r_out_valid || i_ready;
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_pop        = w_out_take && !w_fifo_empty;
    assign w_push       = r_rd_valid && !(w_out_take && w_fifo_empty);

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo_mem[r_fifo_wp] <= w_rd_payload;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fifo_wp     <= 1'b0;
            r_fifo_rp     <= 1'b0;
            r_fifo_cnt    <= 2'd0;
            r_out_valid   <= 1'b0;
            r_out_payload <= '0;
        end else begin
            if (w_push) r_fifo_wp <= ~r_fifo_wp;
            if (w_pop) r_fifo_rp <= ~r_fifo_rp;
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_out_take) begin
                if (!w_fifo_empty) begin
                    r_out_valid   <= 1'b1;
                    r_out_payload <= r_fifo_mem[r_fifo_rp];
                end else if (r_rd_valid) begin
                    r_out_valid   <= 1'b1;
                    r_out_payload <= w_rd_payload;
                end else begin
                    r_out_valid   <= 1'b0;
                end
            end
        end
    end

    assign o_valid       = r_out_valid;
    assign o_data_0_real = r_out_payload[PLW-1 -: DATA_W];
    assign o_data_0_imag = r_out_payload[PLW-DATA_W-1 -: DATA_W];
    assign o_data_1_real = r_out_payload[PLW-2*DATA_W-1 -: DATA_W];
    assign o_data_1_imag = r_out_payload[PW+DATA_W-1 -: DATA_W];
    assign o_pair_idx    = r_out_payload[PW-1:0];
    assign o_last        = r_out_valid && (&r_out_payload[PW-1:0]);
    assign o_frame_drop  = r_frame_drop;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_fft_output_unloader.sv
// Bench for fft_output_unloader: a frame-level reorder model feeds an expected queue that the
// output monitor drains on every transfer, plus literal checks on reset, timing and a few bins.
module tb_fft_output_unloader;
    localparam int DATA_W = 32;
    localparam int LOG2N  = 10;
    localparam int NP     = 512;
    localparam int PLW    = 4 * DATA_W + 9;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_valid_in = 1'b0;
    logic [DATA_W-1:0] i_data_a_real = '0, i_data_a_imag = '0;
    logic [DATA_W-1:0] i_data_b_real = '0, i_data_b_imag = '0;
    logic              i_ready = 1'b0;
    logic              o_valid, o_last, o_frame_drop, o_overflow;
    logic [DATA_W-1:0] o_data_0_real, o_data_0_imag, o_data_1_real, o_data_1_imag;
    logic [LOG2N-2:0]  o_pair_idx;

    int vectors = 0;
    int miscompares = 0;
    logic [PLW-1:0] exp_q[$];
    logic [31:0] m_a_re[NP], m_a_im[NP], m_b_re[NP], m_b_im[NP];
    int m_k = 0;
    int exp_drops = 0;
    int drops_seen = 0;
    int ready_mode = 0;
    bit pin_en = 1'b0;
    logic [31:0] obs_d0r[NP], obs_d1r[NP], obs_d1i[NP];
    bit b2b_en = 1'b0;
    bit b2b_started = 1'b0;
    int b2b_xfers = 0;
    int b2b_gaps = 0;

    fft_output_unloader #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid_in(i_valid_in),
        .i_data_a_real(i_data_a_real), .i_data_a_imag(i_data_a_imag),
        .i_data_b_real(i_data_b_real), .i_data_b_imag(i_data_b_imag),
        .i_ready(i_ready), .o_valid(o_valid),
        .o_data_0_real(o_data_0_real), .o_data_0_imag(o_data_0_imag),
        .o_data_1_real(o_data_1_real), .o_data_1_imag(o_data_1_imag),
        .o_pair_idx(o_pair_idx), .o_last(o_last),
        .o_frame_drop(o_frame_drop), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // 0: ready always high, 1: ready 30% high, 2: ready low
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(0, 9) < 3);
            default: i_ready = 1'b0;
        endcase
    end

    function automatic int rev9(input int v);
        int r = 0;
        for (int i = 0; i < 9; i++) if (((v >> i) & 1) == 1) r += 1 << (8 - i);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bin n < 512 holds a-sample k with rev9(k) = n; bin n >= 512 holds b-sample k with rev9(k) = n - 512.
    task automatic model_frame_done(input bit dropped);
        logic [31:0] bre[1024];
        logic [31:0] bim[1024];
        if (dropped) begin
            exp_drops++;
            return;
        end
        for (int k = 0; k < NP; k++) begin
            bre[rev9(k)]       = m_a_re[k];
            bim[rev9(k)]       = m_a_im[k];
            bre[512 + rev9(k)] = m_b_re[k];
            bim[512 + rev9(k)] = m_b_im[k];
        end
        for (int j = 0; j < NP; j++)
            exp_q.push_back({bre[2*j], bim[2*j], bre[2*j+1], bim[2*j+1], 9'(j)});
    endtask

    task automatic idle(input int n);
        i_valid_in = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_pair(input logic [31:0] ar, ai, br, bi, input bit dropped);
        i_valid_in    = 1'b1;
        i_data_a_real = ar;
        i_data_a_imag = ai;
        i_data_b_real = br;
        i_data_b_imag = bi;
        @(posedge i_clk);
        #1;
        i_valid_in = 1'b0;
        m_a_re[m_k] = ar;
        m_a_im[m_k] = ai;
        m_b_re[m_k] = br;
        m_b_im[m_k] = bi;
        m_k++;
        if (m_k == NP) begin
            m_k = 0;
            model_frame_done(dropped);
        end
    endtask

    task automatic send_frame(input logic [31:0] base_a, base_b, input int gap, input bit dropped);
        logic [31:0] va, vb;
        for (int k = 0; k < NP; k++) begin
            va = base_a + 32'(k);
            vb = base_b + 32'(k);
            send_pair(va, -va, vb, -vb, dropped);
            if (gap > 0 && k != NP - 1) idle(gap);
        end
    endtask

    task automatic drain(input string name, input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        idle(4);
    endtask

    task automatic check_first_valid_timing(input string name);
        check({name, "_valid_at_e0"}, 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check({name, "_valid_after_e1"}, 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check({name, "_valid_after_e2"}, 64'(o_valid), 64'd1);
        check({name, "_first_idx"}, 64'(o_pair_idx), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, 64'(o_valid), 64'd0);
        check({name, "_data0"}, {o_data_0_real, o_data_0_imag}, 64'd0);
        check({name, "_data1"}, {o_data_1_real, o_data_1_imag}, 64'd0);
        check({name, "_idx"}, 64'(o_pair_idx), 64'd0);
        check({name, "_last"}, 64'(o_last), 64'd0);
        check({name, "_drop"}, 64'(o_frame_drop), 64'd0);
        check({name, "_overflow"}, 64'(o_overflow), 64'd0);
    endtask

    task automatic monitor();
        logic held = 1'b0;
        logic [PLW+1:0] saved = '0;
        logic [PLW-1:0] act, e;
        forever begin
            @(negedge i_clk);
            act = {o_data_0_real, o_data_0_imag, o_data_1_real, o_data_1_imag, o_pair_idx};
            if (!i_reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    vectors++;
                    if ({act, o_last, o_valid} !== saved) begin
                        miscompares++;
                        $display("FAIL hold_stable: got %0h, expected %0h", {act, o_last, o_valid}, saved);
                    end
                end
                held  = o_valid && !i_ready;
                saved = {act, o_last, o_valid};
                if (o_valid && i_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_output: got pair_idx %0d, expected no output", o_pair_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e || o_last !== (e[8:0] == 9'd511)) begin
                            miscompares++;
                            $display("FAIL pair_j%0d: got %0h last %0b, expected %0h last %0b",
                                     e[8:0], act, o_last, e, (e[8:0] == 9'd511));
                        end
                    end
                    if (pin_en) begin
                        obs_d0r[o_pair_idx] = o_data_0_real;
                        obs_d1r[o_pair_idx] = o_data_1_real;
                        obs_d1i[o_pair_idx] = o_data_1_imag;
                    end
                    if (b2b_en) begin
                        b2b_xfers++;
                        b2b_started = 1'b1;
                    end
                end else if (b2b_en && b2b_started && b2b_xfers < 4 * NP && !o_valid) begin
                    b2b_gaps++;
                end
                if (o_frame_drop) drops_seen++;
            end
        end
    endtask

    task automatic run_tests();
        // Reset values
        ready_mode = 0;
        i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs_zero("reset");
        i_reset = 1'b1;
        idle(2);

        // Impulse-style frame with hand-computed bins
        pin_en = 1'b1;
        send_frame(32'd1000, 32'd2000, 0, 1'b0);
        check_first_valid_timing("impulse");
        drain("impulse", 2000);
        pin_en = 1'b0;
        check("pin_j0_bin0", 64'(obs_d0r[0]), 64'd1000);
        check("pin_j0_bin1", 64'(obs_d1r[0]), 64'd1256);
        check("pin_j3_bin6", 64'(obs_d0r[3]), 64'd1192);
        check("pin_j3_bin7", 64'(obs_d1r[3]), 64'd1448);
        check("pin_j3_bin7_imag", 64'(obs_d1i[3]), 64'h0000_0000_FFFF_FA58);
        check("pin_j256_bin512", 64'(obs_d0r[256]), 64'd2000);
        check("pin_j256_bin513", 64'(obs_d1r[256]), 64'd2256);
        check("pin_j511_bin1022", 64'(obs_d0r[511]), 64'd2255);
        check("pin_j511_bin1023", 64'(obs_d1r[511]), 64'd2511);

        // Back-to-back frames
        b2b_en = 1'b1;
        for (int f = 0; f < 4; f++)
            send_frame(32'(5000 + 1000 * f), 32'(5500 + 1000 * f), 0, 1'b0);
        drain("b2b", 3000);
        b2b_en = 1'b0;
        check("b2b_xfers", 64'(b2b_xfers), 64'd2048);
        check("b2b_gaps", 64'(b2b_gaps), 64'd0);
        check("b2b_overflow", 64'(o_overflow), 64'd0);
        check("b2b_drops", 64'(drops_seen), 64'(exp_drops));

        // Random backpressure, extreme values to exercise pass-through
        ready_mode = 1;
        send_frame(32'h7FFF_FE00, 32'h8000_0000, 0, 1'b0);
        drain("backpressure", 10000);
        ready_mode = 0;
        idle(2);

        // Input valid 1 in 3
        send_frame(32'd11000, 32'd12000, 2, 1'b0);
        check_first_valid_timing("gaps");
        drain("gaps", 2000);

        // Overflow: reader stalls on frame 1, frames 2 and 3 complete while it is busy
        ready_mode = 2;
        send_frame(32'd20000, 32'd21000, 0, 1'b0);
        send_frame(32'd30000, 32'd31000, 0, 1'b1);
        send_frame(32'd40000, 32'd41000, 0, 1'b1);
        idle(3);
        check("ovf_drop_count", 64'(drops_seen), 64'(exp_drops));
        check("ovf_drop_literal", 64'(drops_seen), 64'd2);
        check("ovf_sticky", 64'(o_overflow), 64'd1);
        check("ovf_held_valid", 64'(o_valid), 64'd1);
        check("ovf_held_idx", 64'(o_pair_idx), 64'd0);
        ready_mode = 0;
        drain("overflow", 2000);
        check("ovf_sticky_after", 64'(o_overflow), 64'd1);

        // Reset in the middle of a frame
        for (int k = 0; k < 200; k++)
            send_pair(32'(9000 + k), 32'(9100 + k), 32'(9200 + k), 32'(9300 + k), 1'b0);
        i_reset = 1'b0;
        exp_q.delete();
        m_k = 0;
        #2;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        idle(2);
        send_frame(32'd13000, 32'd14000, 0, 1'b0);
        drain("post_reset", 2000);
        check("post_reset_overflow", 64'(o_overflow), 64'd0);
        check("post_reset_drops", 64'(drops_seen), 64'(exp_drops));
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
